// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use stall, taken-branch flush
// and multi-cycle mult/div hold of EX. Optional macro HAZARD_STATS_EN adds StallCycles.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IdRs,
  input  logic [4:0]  IdRt,
  input  logic        IdUsesRt,
  input  logic [4:0]  ExRt,
  input  logic        ExMemtoReg,
  input  logic        ExMdStart,
  input  logic        BranchTaken,
  output logic        PcWrite,
  output logic        IfIdWrite,
  output logic        IfIdFlush,
  output logic        IdExClear,
  output logic        ExHold,
`ifdef HAZARD_STATS_EN
  output logic        ExMemBubble,
  output logic [31:0] StallCycles
`else
  output logic        ExMemBubble
`endif
);

  localparam int CW = $clog2(MD_LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LATENCY - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MD_BUSY = 2'b01
  } state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic          hold;
  logic          loadUse;

  // State and countdown register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state, hold condition and Mealy hazard controls
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    hold        = 1'b0;
    PcWrite     = 1'b1;
    IfIdWrite   = 1'b1;
    IfIdFlush   = 1'b0;
    IdExClear   = 1'b0;
    ExHold      = 1'b0;
    ExMemBubble = 1'b0;

    case (state)
      IDLE: begin
        if (ExMdStart) begin
          hold      = 1'b1;
          stateNext = MD_BUSY;
          cntNext   = CNT_LOAD;
        end else begin
          stateNext = IDLE;
        end
      end
      MD_BUSY: begin
        // cnt==0 is the release cycle: the pipeline advances and ExMdStart is ignored
        if (cnt != CNT_ZERO) begin
          hold    = 1'b1;
          cntNext = cnt - CNT_ONE;
        end else begin
          stateNext = IDLE;
          cntNext   = CNT_ZERO;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = CNT_ZERO;
      end
    endcase

    loadUse = ExMemtoReg && (ExRt != 5'd0) &&
              ((ExRt == IdRs) || (IdUsesRt && (ExRt == IdRt)));

    if (reset) begin
      PcWrite   = 1'b1;
      IfIdWrite = 1'b1;
    end else if (hold) begin
      PcWrite     = 1'b0;
      IfIdWrite   = 1'b0;
      ExHold      = 1'b1;
      ExMemBubble = 1'b1;
    end else if (loadUse) begin
      PcWrite   = 1'b0;
      IfIdWrite = 1'b0;
      IdExClear = 1'b1;
    end else if (BranchTaken) begin
      IfIdFlush = 1'b1;
    end else begin
      PcWrite   = 1'b1;
      IfIdWrite = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating count of edges on which the PC was stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCycles <= 32'd0;
    end else if (!PcWrite && (StallCycles != 32'hFFFF_FFFF)) begin
      StallCycles <= StallCycles + 32'd1;
    end else begin
      StallCycles <= StallCycles;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized stimulus
// against an occupancy-based reference model.
module tb_hazard_ctrl;

  localparam int MDL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IdRs, IdRt, ExRt;
  logic       IdUsesRt, ExMemtoReg, ExMdStart, BranchTaken;
  logic       PcWrite, IfIdWrite, IfIdFlush, IdExClear, ExHold, ExMemBubble;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCycles;
`endif

  hazard_ctrl #(.MD_LATENCY(MDL)) dut (
    .clk(clk), .reset(reset), .IdRs(IdRs), .IdRt(IdRt), .IdUsesRt(IdUsesRt),
    .ExRt(ExRt), .ExMemtoReg(ExMemtoReg), .ExMdStart(ExMdStart),
    .BranchTaken(BranchTaken), .PcWrite(PcWrite), .IfIdWrite(IfIdWrite),
    .IfIdFlush(IfIdFlush), .IdExClear(IdExClear), .ExHold(ExHold),
`ifdef HAZARD_STATS_EN
    .ExMemBubble(ExMemBubble), .StallCycles(StallCycles)
`else
    .ExMemBubble(ExMemBubble)
`endif
  );

  always #5 clk = ~clk;

  // {PcWrite, IfIdWrite, IfIdFlush, IdExClear, ExHold, ExMemBubble}
  logic [5:0] outs;
  assign outs = {PcWrite, IfIdWrite, IfIdFlush, IdExClear, ExHold, ExMemBubble};

  localparam logic [5:0] O_DEF  = 6'b110000;
  localparam logic [5:0] O_HOLD = 6'b000011;
  localparam logic [5:0] O_LU   = 6'b000100;
  localparam logic [5:0] O_BR   = 6'b111000;

  int passCnt = 0;
  int totalCnt = 0;
  int occ = 0;          // EX occupancy cycles remaining after the current one
  longint statModel = 0;
  logic [5:0] exp;

  // Reference: priority hold > load-use > branch, derived from occupancy count
  function automatic logic [5:0] expOut();
    logic h, l;
    if (reset) return O_DEF;
    h = (occ == 0) ? ExMdStart : (occ > 1);
    l = ExMemtoReg && (ExRt != 5'd0) &&
        ((ExRt == IdRs) || (IdUsesRt && (ExRt == IdRt)));
    if (h) return O_HOLD;
    if (l) return O_LU;
    if (BranchTaken) return O_BR;
    return O_DEF;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic [4:0] exrt, input logic mem, input logic md,
                       input logic br);
    IdRs = rs; IdRt = rt; IdUsesRt = uses; ExRt = exrt;
    ExMemtoReg = mem; ExMdStart = md; BranchTaken = br;
  endtask

  // Clock edge plus model update; e is the expected control vector for this cycle
  task automatic advance(input logic [5:0] e);
    @(posedge clk);
    if (reset) begin
      occ = 0;
      statModel = 0;
    end else begin
      if (e[5] == 1'b0) statModel = statModel + 1;
      if (occ == 0 && ExMdStart) occ = MDL - 1;
      else if (occ > 0) occ = occ - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    occ = 0; statModel = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    occ = 0; statModel = 0;
    // inputs that would otherwise hold must be ignored under reset
    drive(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    #2;
    totalCnt++;
    if (outs !== O_DEF) $display("FAIL reset_outputs got=%b exp=%b", outs, O_DEF);
    else passCnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    totalCnt++;
    if (outs !== O_DEF) $display("FAIL post_reset_idle got=%b exp=%b", outs, O_DEF);
    else passCnt++;
    advance(O_DEF);
  endtask

  task automatic test_load_use();
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk); exp = expOut();
    totalCnt++;
    if (outs !== O_LU || exp !== O_LU) $display("FAIL load_use_stall got=%b exp=%b", outs, O_LU);
    else passCnt++;
    advance(exp);
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk); exp = expOut();
    totalCnt++;
    if (outs !== O_DEF) $display("FAIL load_use_release got=%b exp=%b", outs, O_DEF);
    else passCnt++;
    advance(exp);
  endtask

  task automatic test_zero_reg();
    drive(5'd0, 5'd3, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); exp = expOut();
    totalCnt++;
    if (outs !== O_DEF) $display("FAIL zero_reg_no_stall got=%b exp=%b", outs, O_DEF);
    else passCnt++;
    advance(exp);
    drive(5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    @(negedge clk); exp = expOut();
    totalCnt++;
    if (outs !== O_DEF) $display("FAIL unused_rt_no_stall got=%b exp=%b", outs, O_DEF);
    else passCnt++;
    advance(exp);
    drive(5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    @(negedge clk); exp = expOut();
    totalCnt++;
    if (outs !== O_LU) $display("FAIL used_rt_stall got=%b exp=%b", outs, O_LU);
    else passCnt++;
    advance(exp);
  endtask

  task automatic test_md();
    int holds = 0;
    for (int c = 0; c < MDL + 1; c++) begin
      // ExMdStart stays high through the release cycle and must be ignored there
      drive(5'd2, 5'd2, 1'b1, 5'd2, 1'b1, (c < MDL) ? 1'b1 : 1'b0, 1'b1);
      @(negedge clk); exp = expOut();
      if (c < MDL - 1) begin
        totalCnt++;
        if (outs !== O_HOLD) $display("FAIL md_hold_c%0d got=%b exp=%b", c, outs, O_HOLD);
        else passCnt++;
      end else begin
        totalCnt++;
        if (outs !== O_LU) $display("FAIL md_release_c%0d got=%b exp=%b", c, outs, O_LU);
        else passCnt++;
      end
      if (outs[1]) holds++;
      advance(exp);
    end
    totalCnt++;
    if (holds != MDL - 1) $display("FAIL md_hold_count got=%0d exp=%0d", holds, MDL - 1);
    else passCnt++;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); exp = expOut();
    totalCnt++;
    if (outs !== O_DEF) $display("FAIL md_idle_after got=%b exp=%b", outs, O_DEF);
    else passCnt++;
    advance(exp);
  endtask

  task automatic test_load_branch();
    drive(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    @(negedge clk); exp = expOut();
    totalCnt++;
    if (outs !== O_LU) $display("FAIL lu_beats_branch got=%b exp=%b", outs, O_LU);
    else passCnt++;
    advance(exp);
    drive(5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
    @(negedge clk); exp = expOut();
    totalCnt++;
    if (outs !== O_BR) $display("FAIL branch_flush got=%b exp=%b", outs, O_BR);
    else passCnt++;
    advance(exp);
  endtask

  task automatic test_reset_mid();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); exp = expOut();
    advance(exp);
    @(negedge clk);
    totalCnt++;
    if (outs !== O_HOLD) $display("FAIL mid_second_hold got=%b exp=%b", outs, O_HOLD);
    else passCnt++;
    reset = 1'b1;
    #1;
    totalCnt++;
    if (PcWrite !== 1'b1 || ExHold !== 1'b0)
      $display("FAIL mid_reset_abort got=PcWrite%b/ExHold%b exp=1/0", PcWrite, ExHold);
    else passCnt++;
    occ = 0; statModel = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); exp = expOut();
    totalCnt++;
    if (outs !== O_DEF) $display("FAIL mid_reset_idle got=%b exp=%b", outs, O_DEF);
    else passCnt++;
    advance(exp);
    // a fresh sequence must give a full set of hold cycles
    for (int c = 0; c < MDL; c++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, (c == 0) ? 1'b1 : 1'b0, 1'b0);
      @(negedge clk); exp = expOut();
      totalCnt++;
      if (outs !== exp) $display("FAIL mid_reset_fresh_c%0d got=%b exp=%b", c, outs, exp);
      else passCnt++;
      advance(exp);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 2 * MDL + 1; c++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); exp = expOut();
      totalCnt++;
      if (outs !== exp) $display("FAIL b2b_c%0d got=%b exp=%b", c, outs, exp);
      else passCnt++;
      advance(exp);
    end
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    while (occ != 0) begin
      @(negedge clk); exp = expOut();
      advance(exp);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 7) == 0),
            1'($urandom));
      @(negedge clk); exp = expOut();
      totalCnt++;
      if (outs !== exp) $display("FAIL random_c%0d got=%b exp=%b", c, outs, exp);
      else passCnt++;
      advance(exp);
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    do_reset();
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk); exp = expOut(); advance(exp);
    for (int c = 0; c < MDL; c++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, (c == 0) ? 1'b1 : 1'b0, 1'b0);
      @(negedge clk); exp = expOut(); advance(exp);
    end
    totalCnt++;
    if (StallCycles !== 32'(statModel) || statModel != 4)
      $display("FAIL stats_count got=%0d exp=%0d", StallCycles, statModel);
    else passCnt++;
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_zero_reg();
    test_md();
    test_load_branch();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the 5-stage MIPS core; it consumes the fields the ID/EX register presents to EX.
- It drives the stall, flush and clear controls back into PC, IF/ID and ID/EX, and the bubble control into EX/MEM.
- It detects load-use hazards and applies a taken-branch flush.
- It sequences a multi-cycle mult/div occupancy of EX with an FSM and down-counter.

## Interface
Parameters:
- MD_LATENCY, 4: total cycles a mult/div instruction occupies EX; legal range 2..16.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- IdRs  in  5  rs of the instruction in ID.
- IdRt  in  5  rt of the instruction in ID.
- IdUsesRt  in  1  the ID instruction reads rt as a source.
- ExRt  in  5  rtOut of the ID/EX register.
- ExMemtoReg  in  1  MemtoRegOut of the ID/EX register; marks a load in EX.
- ExMdStart  in  1  the instruction in EX is mult/div, decoded from ALUControlOut.
- BranchTaken  in  1  a branch resolved taken in ID this cycle.
- PcWrite  out  1  PC load enable.
- IfIdWrite  out  1  IF/ID load enable.
- IfIdFlush  out  1  zero IF/ID on the next edge.
- IdExClear  out  1  load a bubble into ID/EX on the next edge.
- ExHold  out  1  ID/EX holds its contents on the next edge.
- ExMemBubble  out  1  EX/MEM loads a bubble (RegWrite=0, MemWrite=0) on the next edge.

## Operation
- **States:** IDLE, MD_BUSY.
- **Counter:** cnt, width ceil(log2(MD_LATENCY)).
- **Output style:** all outputs are Mealy: combinational from state, cnt and the inputs.

Hold condition:
- H = (IDLE and ExMdStart) or (MD_BUSY and cnt != 0).
- While H: PcWrite=0, IfIdWrite=0, ExHold=1, ExMemBubble=1, IdExClear=0, IfIdFlush=0.
- BranchTaken and load-use are ignored while H holds.

Transitions:
- IDLE with ExMdStart=1 -> MD_BUSY, cnt <= MD_LATENCY-2.
- MD_BUSY with cnt != 0 -> MD_BUSY, cnt <= cnt-1.
- MD_BUSY with cnt == 0 -> IDLE. This is the release cycle: H=0, ExMdStart is ignored, and the pipeline advances.
- Result: EX occupancy = MD_LATENCY cycles, of which MD_LATENCY-1 are hold cycles.

Load-use hazard, evaluated when H=0:
- L = ExMemtoReg and ExRt != 0 and (ExRt == IdRs or (IdUsesRt and ExRt == IdRt)).
- L=1 -> PcWrite=0, IfIdWrite=0, IdExClear=1, IfIdFlush=0.
- The bubble makes ExMemtoReg=0 on the next cycle, so the stall lasts exactly 1 cycle.

Branch:
- When H=0 and L=0, BranchTaken=1 -> IfIdFlush=1, PcWrite=1, IfIdWrite=1.
- When L=1, BranchTaken is suppressed. The branch is re-resolved on the next cycle with the forwarded operand.

Priority: mult/div hold > load-use > branch flush.

Default (none of the above): PcWrite=1, IfIdWrite=1, all other outputs 0.

Unreachable state encodings -> IDLE, cnt=0, on the next edge.

## Timing
- **Reset:** asynchronous. While reset=1: state=IDLE, cnt=0, PcWrite=1, IfIdWrite=1, all other outputs 0, regardless of the inputs.
- **Reset mid-MD_BUSY:** the hold sequence aborts immediately. After reset deasserts, the first edge starts from IDLE.
- **Latency:** all controls are valid in the same cycle as their inputs and act on the next clk edge. There is no added latency.
- **MD_LATENCY=2:** entry cycle holds, then MD_BUSY with cnt=0 releases. The result is 1 hold cycle.
- **Back-to-back mult/div:** the second ExMdStart is observed only in the IDLE cycle after release. It starts a fresh sequence with no gap cycles.
- **ExRt=0 loads** never stall.

## Configuration
- **HAZARD_STATS_EN:** when defined, adds output StallCycles (out, 32 bits).
  - Increments on every clk edge where PcWrite=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared to 0 by reset.
- **Without the macro:** the port and the counter are absent, and the remaining behaviour is identical.

## Test plan
- **Load-use:** ExMemtoReg=1, ExRt=5, IdRs=5 -> one cycle of PcWrite=0, IfIdWrite=0, IdExClear=1. Next cycle ExMemtoReg=0 -> defaults restored.
- **Zero register / unused rt:** ExRt=0=IdRs with ExMemtoReg=1 -> no stall. ExRt=7=IdRt with IdUsesRt=0 -> no stall.
- **Mult/div, MD_LATENCY=4:** ExMdStart pulse held -> ExHold=ExMemBubble=1 for exactly 3 cycles, release on the 4th, then IDLE.
- **Simultaneous load-use + BranchTaken:** -> IdExClear=1, IfIdFlush=0. Next cycle BranchTaken alone -> IfIdFlush=1.
- **Reset mid-sequence:** reset asserted in the 2nd hold cycle -> outputs immediately PcWrite=1, ExHold=0. After release, the state is IDLE and cnt=0.
- **HAZARD_STATS_EN:** one load-use stall plus one MD_LATENCY=4 sequence -> StallCycles=4.
